// File: rtl/wb_master_msg_queue.sv
// Outbound WISHBONE message queue: a circular chunk FIFO paired with a descriptor FIFO of
// complete messages. The head message is presented one chunk at a time and can be rewound for a retry.
module wb_master_msg_queue #(
    parameter int DEPTH_LOG2          = 4,
    parameter int MSG_LOG2            = 2,
    parameter int N_BITS_BURST_LENGHT = 7,
    parameter int BUS_ADDRESS_WIDTH   = 32,
    parameter int BUS_DATA_WIDTH      = 32,
    parameter int GRANULARITY         = 8,
    parameter int BUS_TGA_WIDTH       = 8,
    parameter int BUS_TGC_WIDTH       = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr_valid_i,
    output logic                                       wr_ready_o,
    input  logic                                       wr_last_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]               wr_address_i,
    input  logic [BUS_DATA_WIDTH-1:0]                  wr_data_i,
    input  logic [BUS_DATA_WIDTH/GRANULARITY-1:0]      wr_sel_i,
    input  logic [BUS_TGA_WIDTH-1:0]                   wr_tga_i,
    input  logic [BUS_TGC_WIDTH-1:0]                   wr_tgc_i,
    input  logic                                       wr_we_i,
    output logic                                       r_bus_arbitration_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]               address_o,
    output logic [BUS_DATA_WIDTH-1:0]                  data_o,
    output logic [BUS_DATA_WIDTH/GRANULARITY-1:0]      sel_o,
    output logic [BUS_TGA_WIDTH-1:0]                   tga_o,
    output logic [BUS_TGC_WIDTH-1:0]                   tgc_o,
    output logic                                       transaction_type_o,
    output logic [N_BITS_BURST_LENGHT-1:0]             burst_lenght_o,
    input  logic                                       next_data_i,
    input  logic                                       message_transmitted_i,
    input  logic                                       retry_i,
    output logic                                       len_err_o
);

    localparam int DEPTH     = 2 ** DEPTH_LOG2;
    localparam int N_MSG     = 2 ** MSG_LOG2;
    localparam int SEL_W     = BUS_DATA_WIDTH / GRANULARITY;
    localparam int LW        = N_BITS_BURST_LENGHT;
    localparam int UW        = DEPTH_LOG2 + 1;
    localparam int BURST_MAX = 2 ** LW - 1;
    localparam int MAX_LEN   = (DEPTH < BURST_MAX) ? DEPTH : BURST_MAX;
    localparam int CHUNK_W   = BUS_ADDRESS_WIDTH + BUS_DATA_WIDTH + SEL_W + BUS_TGA_WIDTH + BUS_TGC_WIDTH;

    logic [CHUNK_W-1:0]    chunk_mem [DEPTH];
    logic [LW-1:0]         desc_len_mem [N_MSG];
    logic                  desc_we_mem [N_MSG];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, head_ptr_q, head_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]         used_q, used_d;
    logic [LW-1:0]         cur_len_q, cur_len_d;
    logic                  cur_we_q, cur_we_d;
    logic                  len_err_q, len_err_d;
    logic [MSG_LOG2-1:0]   desc_wr_ptr_q, desc_wr_ptr_d, desc_rd_ptr_q, desc_rd_ptr_d;
    logic [MSG_LOG2:0]     desc_cnt_q, desc_cnt_d;

    logic                  desc_full, head_valid, wr_accept, at_max, wr_store, wr_commit, pop, can_adv;
    logic [LW-1:0]         commit_len, head_len;
    logic                  commit_we, head_we;
    logic [DEPTH_LOG2-1:0] rd_off;
    logic [CHUNK_W-1:0]    chunk_rd;

    assign desc_full  = (desc_cnt_q == (MSG_LOG2 + 1)'(N_MSG));
    assign head_valid = (desc_cnt_q != '0);
    assign wr_ready_o = (used_q < UW'(DEPTH)) && !desc_full;
    assign wr_accept  = wr_valid_i && wr_ready_o;
    // A chunk beyond the maximum burst is consumed from the producer but never stored.
    assign at_max     = (cur_len_q == LW'(MAX_LEN));
    assign wr_store   = wr_accept && !at_max;
    assign wr_commit  = wr_accept && wr_last_i;
    assign commit_len = cur_len_q + LW'(wr_store);
    assign commit_we  = (cur_len_q == '0) ? wr_we_i : cur_we_q;

    assign head_len   = desc_len_mem[desc_rd_ptr_q];
    assign head_we    = desc_we_mem[desc_rd_ptr_q];
    assign rd_off     = rd_ptr_q - head_ptr_q;
    assign can_adv    = (int'(rd_off) + 1) < int'(head_len);
    assign pop        = message_transmitted_i && head_valid;

    always_comb begin
        // NOTE: every next-state value takes its hold value first, so no path can infer a latch.
        wr_ptr_d      = wr_ptr_q;
        head_ptr_d    = head_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cur_len_d     = cur_len_q;
        cur_we_d      = cur_we_q;
        desc_wr_ptr_d = desc_wr_ptr_q;
        desc_rd_ptr_d = desc_rd_ptr_q;
        len_err_d     = len_err_q | (wr_accept && at_max);
        used_d        = used_q + UW'(wr_store) - (pop ? UW'(head_len) : '0);
        desc_cnt_d    = desc_cnt_q + (MSG_LOG2 + 1)'(wr_commit) - (MSG_LOG2 + 1)'(pop);

        if (wr_store) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (wr_accept && cur_len_q == '0) cur_we_d = wr_we_i;
        if (wr_commit) begin
            cur_len_d     = '0;
            desc_wr_ptr_d = desc_wr_ptr_q + MSG_LOG2'(1);
        end else if (wr_store) begin
            cur_len_d = cur_len_q + LW'(1);
        end

        if (pop) begin
            head_ptr_d    = head_ptr_q + DEPTH_LOG2'(head_len);
            rd_ptr_d      = head_ptr_q + DEPTH_LOG2'(head_len);
            desc_rd_ptr_d = desc_rd_ptr_q + MSG_LOG2'(1);
        end else if (retry_i) begin
            rd_ptr_d = head_ptr_q;
        end else if (next_data_i && head_valid && can_adv) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            head_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            used_q        <= '0;
            cur_len_q     <= '0;
            cur_we_q      <= 1'b0;
            len_err_q     <= 1'b0;
            desc_wr_ptr_q <= '0;
            desc_rd_ptr_q <= '0;
            desc_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            head_ptr_q    <= head_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            used_q        <= used_d;
            cur_len_q     <= cur_len_d;
            cur_we_q      <= cur_we_d;
            len_err_q     <= len_err_d;
            desc_wr_ptr_q <= desc_wr_ptr_d;
            desc_rd_ptr_q <= desc_rd_ptr_d;
            desc_cnt_q    <= desc_cnt_d;
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_store) chunk_mem[wr_ptr_q] <= {wr_address_i, wr_data_i, wr_sel_i, wr_tga_i, wr_tgc_i};
        if (wr_commit) begin
            desc_len_mem[desc_wr_ptr_q] <= commit_len;
            desc_we_mem[desc_wr_ptr_q]  <= commit_we;
        end
    end

    assign chunk_rd = chunk_mem[rd_ptr_q];

    always_comb begin
        {address_o, data_o, sel_o, tga_o, tgc_o} = head_valid ? chunk_rd : '0;
        r_bus_arbitration_o = head_valid;
        transaction_type_o  = head_valid && head_we;
        burst_lenght_o      = head_valid ? head_len : '0;
    end

    assign len_err_o = len_err_q;

endmodule
